// File: rtl/gw2a_ddr_rdalign_pkg.sv
// Shared PHY definitions: calibration FSM state codes, sample-select encodings, counter sizing.
// Latency: none (types, constants and a width helper only).
// Backpressure: not applicable.
package gw2a_ddr_rdalign_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FIN    = 3'd4
    } cal_state_t;

    // Low two shift bits choose which deserialiser samples form the pair {a,b}.
    localparam logic [1:0] SEL_S0_S2 = 2'b00;
    localparam logic [1:0] SEL_S1_S3 = 2'b01;
    localparam logic [1:0] SEL_S2_S0 = 2'b10;
    localparam logic [1:0] SEL_S3_S1 = 2'b11;

    // Shift bit 2 moves the pair back by one sample, pulling b from the previous PCLK.
    localparam int SH_DELAY_BIT = 2;

    // Last sample position tried in a sweep; the trial counter stops here.
    localparam logic [2:0] TRIAL_LAST = 3'd7;

    // Width of the shared SETTLE/CHECK cycle counter.
    function automatic int cnt_width(input int settle, input int match);
        int m;
        m = (settle > match) ? settle : match;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/gw2a_ddr_rdsel.sv
// One byte lane of read capture: 4:2 sample mux per DQ bit plus the previous-b register.
// Latency: DI to Q is 1 PCLK when shift[2]=0, 2 PCLK when shift[2]=1.
// Backpressure: none; free-running datapath, a new pair every PCLK.
module gw2a_ddr_rdsel
    import gw2a_ddr_rdalign_pkg::*;
(
    input  logic        PCLK,
    input  logic        RESETN,
    input  logic [31:0] di,
    input  logic [2:0]  shift,
    output logic [7:0]  q0,
    output logic [7:0]  q1
);

    logic [7:0] sel_a;
    logic [7:0] sel_b;
    logic [7:0] b_prev;

    // Pick the {a,b} sample pair for every bit of the lane from the low shift bits.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < 8; i++) begin
            case (shift[1:0])
                SEL_S0_S2: begin sel_a[i] = di[4*i];     sel_b[i] = di[4*i + 2]; end
                SEL_S1_S3: begin sel_a[i] = di[4*i + 1]; sel_b[i] = di[4*i + 3]; end
                SEL_S2_S0: begin sel_a[i] = di[4*i + 2]; sel_b[i] = di[4*i];     end
                SEL_S3_S1: begin sel_a[i] = di[4*i + 3]; sel_b[i] = di[4*i + 1]; end
            endcase
        end
    end

    // Register the aligned pair; the delayed form pairs last cycle's b with this cycle's a.
    always_ff @(posedge PCLK or negedge RESETN) begin
        if (!RESETN) begin
            b_prev <= '0;
            q0     <= '0;
            q1     <= '0;
        end else begin
            b_prev <= sel_b;
            if (shift[SH_DELAY_BIT]) begin
                q0 <= b_prev;
                q1 <= sel_a;
            end else begin
                q0 <= sel_a;
                q1 <= sel_b;
            end
        end
    end

endmodule

// File: rtl/gw2a_ddr_rdalign.sv
// DDR read-capture alignment: per-lane sample shift with a run-time training sweep.
// Latency: Q is 1 PCLK after DI (2 PCLK for delayed shifts); a sweep is at most 8*(SETTLE+MATCH+1)+2 PCLK.
// Backpressure: none on data; CALIB_REQ is dropped unless the controller is idle.
module gw2a_ddr_rdalign
    import gw2a_ddr_rdalign_pkg::*;
#(
    parameter int         WIDTH         = 16,
    parameter int         LANES         = WIDTH / 8,
    parameter logic [2:0] DEFAULT_SHIFT = 3'b000,
    parameter logic [1:0] PATTERN       = 2'b01,
    parameter int         SETTLE        = 4,
    parameter int         MATCH         = 8
) (
    input  logic                 PCLK,
    input  logic                 RESETN,
    input  logic [4*WIDTH-1:0]   DI,
    input  logic                 CALIB_REQ,
    output logic                 CALIB_BUSY,
    output logic                 CALIB_DONE,
    output logic                 CALIB_ERR,
    output logic [LANES-1:0]     LANE_LOCK,
    output logic [3*LANES-1:0]   SHIFT,
    output logic [WIDTH-1:0]     Q0,
    output logic [WIDTH-1:0]     Q1
);

    localparam int CW = cnt_width(SETTLE, MATCH);

    cal_state_t                  state;
    logic [2:0]                  trial;
    logic [CW-1:0]               cnt;
    logic [LANES-1:0][2:0]       lane_shift;
    logic [LANES-1:0]            lane_fail;
    logic [LANES-1:0]            lane_match;
    logic [LANES-1:0]            lock_nxt;

    assign SHIFT = lane_shift;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        gw2a_ddr_rdsel u_rdsel (
            .PCLK   (PCLK),
            .RESETN (RESETN),
            .di     (DI[32*k +: 32]),
            .shift  (lane_shift[k]),
            .q0     (Q0[8*k +: 8]),
            .q1     (Q1[8*k +: 8])
        );
    end

    // A lane matches this cycle only if every one of its bits shows the training pair.
    always_comb begin
        lane_match = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_match[k] = 1'b1;
            for (int i = 0; i < 8; i++) begin
                if ({Q1[8*k + i], Q0[8*k + i]} != PATTERN) begin
                    lane_match[k] = 1'b0;
                end
            end
        end
    end

    // Locks after the current trial: earlier locks plus every lane clean through CHECK.
    always_comb begin
        lock_nxt = LANE_LOCK | ~lane_fail;
    end

    // Calibration sweep: settle, check, lock passing lanes, advance trial, finish.
    always_ff @(posedge PCLK or negedge RESETN) begin
        if (!RESETN) begin
            state      <= ST_IDLE;
            trial      <= '0;
            cnt        <= '0;
            lane_fail  <= '0;
            lane_shift <= {LANES{DEFAULT_SHIFT}};
            LANE_LOCK  <= '0;
            CALIB_BUSY <= 1'b0;
            CALIB_DONE <= 1'b0;
            CALIB_ERR  <= 1'b0;
        end else begin
            CALIB_DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (CALIB_REQ) begin
                        state      <= ST_SETTLE;
                        trial      <= '0;
                        cnt        <= '0;
                        lane_fail  <= '0;
                        lane_shift <= '0;
                        LANE_LOCK  <= '0;
                        CALIB_ERR  <= 1'b0;
                        CALIB_BUSY <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == CW'(SETTLE - 1)) begin
                        cnt   <= '0;
                        state <= ST_CHECK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    lane_fail <= lane_fail | ~lane_match;
                    if (cnt == CW'(MATCH - 1)) begin
                        cnt   <= '0;
                        state <= ST_NEXT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_NEXT: begin
                    LANE_LOCK <= lock_nxt;
                    if ((&lock_nxt) || (trial == TRIAL_LAST)) begin
                        state <= ST_FIN;
                    end else begin
                        trial     <= trial + 3'd1;
                        lane_fail <= '0;
                        state     <= ST_SETTLE;
                        for (int k = 0; k < LANES; k++) begin
                            if (!lock_nxt[k]) begin
                                lane_shift[k] <= trial + 3'd1;
                            end
                        end
                    end
                end
                ST_FIN: begin
                    for (int k = 0; k < LANES; k++) begin
                        if (!LANE_LOCK[k]) begin
                            lane_shift[k] <= DEFAULT_SHIFT;
                        end
                    end
                    CALIB_ERR  <= |(~LANE_LOCK);
                    CALIB_DONE <= 1'b1;
                    CALIB_BUSY <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gw2a_ddr_rdalign.sv
// Bench for gw2a_ddr_rdalign: emulated read channel, sweep outcome model, datapath model.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_gw2a_ddr_rdalign;

    localparam int         WIDTH  = 16;
    localparam int         LANES  = 2;
    localparam int         SETTLE = 4;
    localparam int         MATCH  = 8;
    localparam logic [2:0] DEF_SH = 3'b000;

    logic                 PCLK = 1'b0;
    logic                 RESETN;
    logic [4*WIDTH-1:0]   DI;
    logic                 CALIB_REQ;
    logic                 CALIB_BUSY;
    logic                 CALIB_DONE;
    logic                 CALIB_ERR;
    logic [LANES-1:0]     LANE_LOCK;
    logic [3*LANES-1:0]   SHIFT;
    logic [WIDTH-1:0]     Q0;
    logic [WIDTH-1:0]     Q1;

    int n_chk  = 0;
    int n_fail = 0;

    // Channel emulation: a lane sees clean training data only at the shifts in its mask.
    logic [7:0] good_mask [LANES];
    bit         direct_mode;

    gw2a_ddr_rdalign #(
        .WIDTH(WIDTH), .DEFAULT_SHIFT(DEF_SH), .PATTERN(2'b01), .SETTLE(SETTLE), .MATCH(MATCH)
    ) dut (
        .PCLK(PCLK), .RESETN(RESETN), .DI(DI), .CALIB_REQ(CALIB_REQ),
        .CALIB_BUSY(CALIB_BUSY), .CALIB_DONE(CALIB_DONE), .CALIB_ERR(CALIB_ERR),
        .LANE_LOCK(LANE_LOCK), .SHIFT(SHIFT), .Q0(Q0), .Q1(Q1)
    );

    initial forever #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sample index a = s[m], b = s[(m+2) mod 4]; the delayed form emits {b_prev, a}.
    function automatic logic [1:0] model_pair(input logic [3:0] cur, input logic [3:0] prev,
                                              input logic [2:0] sh);
        int m;
        int mb;
        m  = int'(sh[1:0]);
        mb = (m + 2) % 4;
        if (sh[2]) return {prev[mb], cur[m]};
        return {cur[m], cur[mb]};
    endfunction

    // Random lane samples, forced so that shift sh yields Q0=1, Q1=0 when good is set.
    function automatic logic [31:0] lane_stim(input logic [2:0] sh, input bit good);
        logic [31:0] v;
        int m;
        int mb;
        v  = $urandom;
        m  = int'(sh[1:0]);
        mb = (m + 2) % 4;
        if (good) begin
            for (int i = 0; i < 8; i++) begin
                v[4*i + m]  = sh[2] ? 1'b0 : 1'b1;
                v[4*i + mb] = sh[2] ? 1'b1 : 1'b0;
            end
        end
        return v;
    endfunction

    // Advance to the next falling edge; in channel mode refresh DI from the lanes' shifts.
    task automatic step();
        logic [2:0] sh;
        @(negedge PCLK);
        if (!direct_mode) begin
            for (int k = 0; k < LANES; k++) begin
                sh = SHIFT[3*k +: 3];
                DI[32*k +: 32] = lane_stim(sh, good_mask[k][sh]);
            end
        end
    endtask

    function automatic int first_set(input logic [7:0] m);
        for (int i = 0; i < 8; i++) if (m[i]) return i;
        return -1;
    endfunction

    // Run one sweep. em0/em1: shifts at which each lane is expected to pass.
    // Sweep length is counted in PCLK cycles from the CALIB_REQ cycle to the CALIB_DONE cycle.
    task automatic do_sweep(input string name, input logic [7:0] gm0, input logic [7:0] gm1,
                            input logic [7:0] em0, input logic [7:0] em1,
                            input int req2_at, input int glitch_at);
        int          f [LANES];
        int          trials;
        int          exp_len;
        int          k;
        bit          got;
        logic [5:0]  exp_sh;
        logic [1:0]  exp_lock;
        good_mask[0] = gm0;
        good_mask[1] = gm1;
        f[0] = first_set(em0);
        f[1] = first_set(em1);
        trials = 0;
        for (int l = 0; l < LANES; l++) begin
            exp_lock[l]       = (f[l] >= 0);
            exp_sh[3*l +: 3]  = (f[l] >= 0) ? 3'(f[l]) : DEF_SH;
            if (f[l] + 1 > trials) trials = f[l] + 1;
        end
        if (exp_lock != 2'b11) trials = 8;
        exp_len = trials * (SETTLE + MATCH + 1) + 2;

        step();
        CALIB_REQ = 1'b1;
        k   = 0;
        got = 1'b0;
        while (k < 300 && !got) begin
            step();
            k++;
            CALIB_REQ = (k == req2_at);
            if (k == glitch_at) DI[31:0] = DI[31:0] & ~32'h1111_1111;
            if (CALIB_DONE) got = 1'b1;
        end
        CALIB_REQ = 1'b0;
        if (!got) begin
            check({name, "_done_timeout"}, 64'(got), 64'd1);
        end else begin
            check({name, "_len"},  64'(k), 64'(exp_len));
            check({name, "_lock"}, 64'(LANE_LOCK), 64'(exp_lock));
            check({name, "_shift"}, 64'(SHIFT), 64'(exp_sh));
            check({name, "_err"},  64'(CALIB_ERR), 64'(exp_lock != 2'b11));
            check({name, "_busy_at_done"}, 64'(CALIB_BUSY), 64'd0);
            step();
            check({name, "_done_pulse"}, 64'(CALIB_DONE), 64'd0);
            check({name, "_busy_after"}, 64'(CALIB_BUSY), 64'd0);
        end
    endtask

    // Random DI against the datapath model at the shifts the sweep is known to have set.
    task automatic datapath_test(input string name, input logic [2:0] sh0, input logic [2:0] sh1,
                                 input int n);
        logic [63:0] d_prev;
        logic [63:0] d_cur;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [1:0]  p;
        logic [2:0]  sh;
        direct_mode = 1'b1;
        d_cur = {$urandom, $urandom};
        d_prev = d_cur;
        DI = d_cur;
        for (int j = 0; j <= n; j++) begin
            step();
            if (j >= 1) begin
                for (int b = 0; b < WIDTH; b++) begin
                    sh = (b < 8) ? sh0 : sh1;
                    p = model_pair(d_cur[4*b +: 4], d_prev[4*b +: 4], sh);
                    e0[b] = p[1];
                    e1[b] = p[0];
                end
                check({name, "_q0"}, 64'(Q0), 64'(e0));
                check({name, "_q1"}, 64'(Q1), 64'(e1));
            end
            d_prev = d_cur;
            d_cur  = {$urandom, $urandom};
            DI     = d_cur;
        end
        direct_mode = 1'b0;
    endtask

    // Single 4'b0110 burst on bit 0 to observe the 1- and 2-cycle capture paths.
    task automatic latency_test(input logic [2:0] sh);
        direct_mode = 1'b1;
        DI = '0;
        step(); step(); step();
        DI[3:0] = 4'b0110;
        step();
        DI = '0;
        if (!sh[2]) begin
            check("lat_sh0_q0", 64'(Q0[0]), 64'd0);
            check("lat_sh0_q1", 64'(Q1[0]), 64'd1);
            step();
            check("lat_sh0_q1_clear", 64'(Q1[0]), 64'd0);
        end else begin
            check("lat_sh4_q0_early", 64'(Q0[0]), 64'd0);
            step();
            check("lat_sh4_q0", 64'(Q0[0]), 64'd1);
        end
        direct_mode = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_q0"},    64'(Q0), 64'd0);
        check({name, "_q1"},    64'(Q1), 64'd0);
        check({name, "_lock"},  64'(LANE_LOCK), 64'd0);
        check({name, "_shift"}, 64'(SHIFT), 64'({DEF_SH, DEF_SH}));
        check({name, "_busy"},  64'(CALIB_BUSY), 64'd0);
        check({name, "_done"},  64'(CALIB_DONE), 64'd0);
        check({name, "_err"},   64'(CALIB_ERR), 64'd0);
    endtask

    // Abort a failing sweep during SETTLE of trial 4 with an asynchronous reset pulse.
    task automatic reset_mid_sweep();
        good_mask[0] = 8'h00;
        good_mask[1] = 8'h00;
        step();
        CALIB_REQ = 1'b1;
        for (int k = 1; k <= 4 * (SETTLE + MATCH + 1) + 2; k++) begin
            step();
            CALIB_REQ = 1'b0;
        end
        check("mid_trial4_shift", 64'(SHIFT), 64'(6'b100_100));
        check("mid_trial4_busy",  64'(CALIB_BUSY), 64'd1);
        RESETN = 1'b0;
        #1;
        check_reset_values("mid_rst");
        step();
        RESETN = 1'b1;
        step(); step();
        check("post_rst_busy", 64'(CALIB_BUSY), 64'd0);
        check("post_rst_lock", 64'(LANE_LOCK), 64'd0);
    endtask

    initial begin
        RESETN      = 1'b0;
        CALIB_REQ   = 1'b0;
        DI          = {$urandom, $urandom};
        direct_mode = 1'b1;
        good_mask[0] = 8'h00;
        good_mask[1] = 8'h00;
        step(); step();
        check_reset_values("rst");
        RESETN = 1'b1;
        step();
        direct_mode = 1'b0;

        latency_test(3'd0);
        datapath_test("dp_sh00", 3'd0, 3'd0, 24);

        do_sweep("sw35", 8'h08, 8'h20, 8'h08, 8'h20, -1, -1);
        datapath_test("dp_sh35", 3'd3, 3'd5, 24);

        do_sweep("sw3x", 8'h08, 8'h00, 8'h08, 8'h00, -1, -1);

        // Second request lands in the FIN cycle and must not restart the sweep.
        do_sweep("sw00", 8'h01, 8'h01, 8'h01, 8'h01, SETTLE + MATCH + 2, -1);

        // Lane 0 also passes at 6; a one-cycle glitch in trial 0 CHECK pushes it there.
        do_sweep("glitch", 8'h41, 8'h01, 8'h40, 8'h01, -1, SETTLE + MATCH / 2 - 1);

        do_sweep("sw44", 8'h10, 8'h10, 8'h10, 8'h10, -1, -1);
        latency_test(3'd4);

        reset_mid_sweep();

        // Extra request while busy must be ignored: the length still matches trial 2 locking.
        do_sweep("busyreq", 8'h04, 8'h04, 8'h04, 8'h04, 5, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
